// File: rtl/bmf_latent_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bmf_latent_decoder
//  Purpose  : Streaming decompressor for BMF-partitioned approximate blocks.
//             Rebuilds an N-bit word from a K-bit latent vector by combining
//             the selected rows of a runtime-programmable basis matrix H,
//             using OR (Boolean) or XOR (GF(2)) as the combining operator.
//             Latent words pass through a DEPTH-word FIFO, then a registered
//             output stage. Both sides use valid/ready handshakes.
//  Ports    : clk, rst        clock (rising edge), async active-high reset
//             mode_i          0 = OR combine, 1 = XOR combine
//             cfg_we_i        basis row write strobe
//             cfg_row_i       basis row index (rows >= K ignored)
//             cfg_data_i      basis row contents
//             cfg_ready_o     basis write accepted (pipeline idle)
//             in_valid_i      latent word valid
//             in_ready_o      FIFO not full
//             in_k_i          latent word, bit i selects row H[i]
//             out_valid_o     output word valid
//             out_ready_i     downstream accepts output
//             out_po_o        reconstructed word
//             out_cnt_o       completed output transfers, saturating
//                             (present only with BMF_DEC_CNT_EN defined)
//  Options  : BMF_DEC_CNT_EN  adds the out_cnt_o transfer counter
//  Revision : 1.0  initial release
// ============================================================================
module bmf_latent_decoder #(
   parameter  int K     = 6,
   parameter  int N     = 8,
   parameter  int DEPTH = 4,
   localparam int ROW_W = (K > 1) ? $clog2(K) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_i,
   input  logic             cfg_we_i,
   input  logic [ROW_W-1:0] cfg_row_i,
   input  logic [N-1:0]     cfg_data_i,
   output logic             cfg_ready_o,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [K-1:0]     in_k_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [N-1:0]     out_po_o
`ifdef BMF_DEC_CNT_EN
   ,
   output logic [15:0]      out_cnt_o
`endif
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [N-1:0] h_q        [K];
   logic [K-1:0] fifo_mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;

   logic         fifo_empty;
   logic         fifo_full;
   logic         push;
   logic         pop;
   logic         cfg_wr;
   logic [K-1:0] head_k;
   logic [N-1:0] dec_word;

   logic         out_valid_q;
   logic         out_valid_d;
   logic [N-1:0] out_po_q;
   logic [N-1:0] out_po_d;

   // Pointers carry one extra wrap bit: equal means empty, equal index with
   // differing wrap bit means full.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_ready_o = ~fifo_full;
   assign push       = in_valid_i & ~fifo_full;
   // Output stage refills whenever it is empty or being drained this cycle.
   assign pop        = ~fifo_empty & (~out_valid_q | out_ready_i);

   // Basis writes only when nothing is in flight and nothing is arriving, so
   // every word is decoded against a single consistent H.
   assign cfg_ready_o = fifo_empty & ~out_valid_q & ~in_valid_i;
   assign cfg_wr      = cfg_we_i & cfg_ready_o;

   assign head_k = fifo_mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      dec_word = '0;
      for (int i = 0; i < K; i++) begin
         if (head_k[i]) begin
            dec_word = mode_i ? (dec_word ^ h_q[i]) : (dec_word | h_q[i]);
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_po_d    = out_po_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_po_d    = dec_word;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_k_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_po_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         out_valid_q <= out_valid_d;
         out_po_q    <= out_po_d;
      end
   end

   // Row match by explicit compare so out-of-range indices write nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K; i++) begin
            h_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < K; i++) begin
            if (cfg_wr && (cfg_row_i == ROW_W'(i))) begin
               h_q[i] <= cfg_data_i;
            end
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_po_o    = out_po_q;

`ifdef BMF_DEC_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_valid_q && out_ready_i && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign out_cnt_o = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmf_latent_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bmf_latent_decoder
//  Purpose  : Directed self-checking bench for bmf_latent_decoder with
//             hand-computed expected words. Optional counter checks follow
//             BMF_DEC_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bmf_latent_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_row = '0;
   logic [7:0] cfg_data = '0;
   logic       cfg_ready;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [5:0] in_k = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_po;
`ifdef BMF_DEC_CNT_EN
   logic [15:0] out_cnt;
`endif

   int total = 0;
   int bad   = 0;

   bmf_latent_decoder #(.K(6), .N(8), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .mode_i      (mode),
      .cfg_we_i    (cfg_we),
      .cfg_row_i   (cfg_row),
      .cfg_data_i  (cfg_data),
      .cfg_ready_o (cfg_ready),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_k_i      (in_k),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_po_o    (out_po)
`ifdef BMF_DEC_CNT_EN
      ,
      .out_cnt_o   (out_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_row(input logic [2:0] r, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_row  = r;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   // One isolated word with out_ready=1: visible after the second edge, gone after the third.
   task automatic send(input string tag, input logic [5:0] k, input logic m, input logic [7:0] exp);
      check({tag, "_rdy"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_k     = k;
      mode     = m;
      tick();
      in_valid = 1'b0;
      check({tag, "_early"}, out_valid, 1'b0);
      tick();
      check({tag, "_vld"}, out_valid, 1'b1);
      check({tag, "_po"}, out_po, exp);
      tick();
   endtask

   logic [7:0] bp_exp [5];

   initial begin
      bp_exp[0] = 8'h07; bp_exp[1] = 8'h08; bp_exp[2] = 8'h12;
      bp_exp[3] = 8'h22; bp_exp[4] = 8'h40;

      // Reset state
      #2;
      check("rst_vld", out_valid, 1'b0);
      check("rst_po", out_po, 8'h00);
      check("rst_inrdy", in_ready, 1'b1);
      check("rst_cfgrdy", cfg_ready, 1'b1);
      tick();
      rst = 1'b0;
      tick();

      // Program basis; row 6 is out of range and must not land anywhere
      wr_row(3'd0, 8'h07);
      wr_row(3'd1, 8'h08);
      wr_row(3'd2, 8'h12);
      wr_row(3'd3, 8'h22);
      wr_row(3'd4, 8'h40);
      wr_row(3'd5, 8'h80);
      wr_row(3'd6, 8'hFF);
      wr_row(3'd7, 8'hFF);

      send("x05", 6'b000101, 1'b1, 8'h15);
      send("o05", 6'b000101, 1'b0, 8'h17);
      send("x0d", 6'b001101, 1'b1, 8'h37);
      send("x00", 6'b000000, 1'b1, 8'h00);
      send("o00", 6'b000000, 1'b0, 8'h00);
      send("x3f", 6'b111111, 1'b1, 8'hFF);
      send("o22", 6'b100010, 1'b0, 8'h88);
      send("x18", 6'b011000, 1'b1, 8'h62);
      send("x0c", 6'b001100, 1'b1, 8'h30);
      send("o0c", 6'b001100, 1'b0, 8'h32);

      // Back-to-back stream, one word per cycle
      mode = 1'b1;
      in_valid = 1'b1; in_k = 6'b000001;
      tick();
      in_k = 6'b000010;
      tick();
      check("str0", out_po, 8'h07);
      in_k = 6'b000100;
      tick();
      check("str1", out_po, 8'h08);
      check("str1_vld", out_valid, 1'b1);
      in_valid = 1'b0;
      tick();
      check("str2", out_po, 8'h12);
      tick();
      check("str_idle", out_valid, 1'b0);

      // Backpressure: 1 in output stage + 4 in FIFO fills the block
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_push_rdy", in_ready, 1'b1);
         in_valid = 1'b1;
         in_k     = 6'(1 << i);
         tick();
      end
      in_valid = 1'b0;
      check("bp_full", in_ready, 1'b0);
      check("bp_cfgrdy", cfg_ready, 1'b0);
      tick();
      tick();
      check("bp_hold_vld", out_valid, 1'b1);
      check("bp_hold_po", out_po, bp_exp[0]);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         if (i == 1) check("bp_rel_rdy", in_ready, 1'b1);
         check("bp_vld", out_valid, 1'b1);
         check("bp_po", out_po, bp_exp[i]);
      end
      tick();
      check("bp_drain", out_valid, 1'b0);

      // Basis write attempted while a word is pending is ignored
      out_ready = 1'b0;
      in_valid = 1'b1; in_k = 6'b000001; mode = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("pend_po", out_po, 8'h07);
      check("pend_cfgrdy", cfg_ready, 1'b0);
      wr_row(3'd0, 8'hFF);
      check("pend_hold", out_po, 8'h07);
      out_ready = 1'b1;
      tick();
      send("pend_after", 6'b000001, 1'b1, 8'h07);

      // Accepted write is used by the next word
      wr_row(3'd0, 8'h01);
      send("newrow", 6'b000101, 1'b1, 8'h13);

      // Asynchronous reset mid-traffic
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_k     = 6'b000011;
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mrst_vld", out_valid, 1'b0);
      check("mrst_po", out_po, 8'h00);
      check("mrst_inrdy", in_ready, 1'b1);
      check("mrst_cfgrdy", cfg_ready, 1'b1);
      tick();
      #2;
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      send("h_clr_o", 6'b111111, 1'b0, 8'h00);
      send("h_clr_x", 6'b111111, 1'b1, 8'h00);

`ifdef BMF_DEC_CNT_EN
      // Reset cleared the counter; two words have transferred since
      check("cnt_after_rst", out_cnt, 16'd2);
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("cnt_10", out_cnt, 16'd10);
      in_valid = 1'b1;
      for (int i = 0; i < 65527; i++) tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("cnt_sat", out_cnt, 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
